// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: default geometry,
// control opcodes and the opcode decoder used by the fetch control path.
package ifu_pkg;

   localparam int IW_DEF          = 16;
   localparam int AW_DEF          = 8;
   localparam int STACK_DEPTH_DEF = 4;

   localparam logic [3:0] OP_JMP  = 4'hF;
   localparam logic [3:0] OP_CALL = 4'hE;
   localparam logic [3:0] OP_RET  = 4'hD;
   localparam logic [3:0] OP_HALT = 4'hC;

   typedef enum logic [2:0] {
      CTL_NONE,
      CTL_JMP,
      CTL_CALL,
      CTL_RET,
      CTL_HALT
   } ctl_e;

   function automatic ctl_e decode_op(input logic [3:0] op);
      ctl_e ctl;
      case (op)
         OP_JMP:  ctl = CTL_JMP;
         OP_CALL: ctl = CTL_CALL;
         OP_RET:  ctl = CTL_RET;
         OP_HALT: ctl = CTL_HALT;
         default: ctl = CTL_NONE;
      endcase
      return ctl;
   endfunction

endpackage

// File: rtl/ifu_ret_stack.sv
// Hardware return stack: push/pop of return addresses with full/empty flags.
// clr empties the stack in one cycle; overflow/underflow are refused here.
module ifu_ret_stack
   import ifu_pkg::*;
#(
   parameter int AW          = AW_DEF,
   parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
   input  logic          clk,
   input  logic          rstz,
   input  logic          clr,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] din,
   output logic [AW-1:0] dout,
   output logic          full,
   output logic          empty
);

   localparam int SPW = $clog2(STACK_DEPTH + 1);

   logic [SPW-1:0] sp_q, sp_d;
   logic [AW-1:0]  ent_q [STACK_DEPTH];
   logic [AW-1:0]  ent_d [STACK_DEPTH];

   assign full  = (int'(sp_q) == STACK_DEPTH);
   assign empty = (sp_q == '0);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      sp_d  = sp_q;
      ent_d = ent_q;
      dout  = '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (i == int'(sp_q) - 1) dout = ent_q[i];
      end
      if (clr) begin
         sp_d = '0;
      end else if (push && !full) begin
         for (int i = 0; i < STACK_DEPTH; i++) begin
            if (i == int'(sp_q)) ent_d[i] = din;
         end
         sp_d = sp_q + SPW'(1);
      end else if (pop && !empty) begin
         sp_d = sp_q - SPW'(1);
      end
   end

   // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) sp_q <= '0;
      else       sp_q <= sp_d;
   end

   // NOTE: storage entries are not reset; sp_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      ent_q <= ent_d;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit with integrated program memory: loads a program in
// programming mode, fetches it in run mode with JMP/CALL/RET/HALT resolution.
module instr_fetch_unit
   import ifu_pkg::*;
#(
   parameter int IW          = IW_DEF,
   parameter int AW          = AW_DEF,
   parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
   input  logic          clk,
   input  logic          rstz,
   input  logic          en,
   input  logic          pr,
   input  logic [IW-1:0] iin,
   input  logic          iin_vld,
   input  logic          stall,
   output logic [IW-1:0] instr,
   output logic          instr_vld,
   output logic [AW-1:0] pc,
   output logic [AW-1:0] wr_addr,
   output logic          halted,
   output logic          stk_err,
   inout  wire           dvdd,
   inout  wire           dgnd
);

   localparam int DEPTH = 2 ** AW;

   logic [IW-1:0] mem [DEPTH];

   logic          pr_q, pr_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [AW-1:0] fpc_q, fpc_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [IW-1:0] instr_q, instr_d;
   logic          instr_vld_q, instr_vld_d;
   logic          halted_q, halted_d;
   logic          stk_err_q, stk_err_d;

   logic          mem_we, rd_en;
   logic          stk_push, stk_pop, stk_clr, stk_full, stk_empty;
   logic [AW-1:0] stk_dout;
   logic [AW-1:0] arg;
   logic          consume;
   ctl_e          ctl;

   logic unused_supply;
   assign unused_supply = dvdd ^ dgnd;

   ifu_ret_stack #(
      .AW          (AW),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_ret_stack (
      .clk   (clk),
      .rstz  (rstz),
      .clr   (stk_clr),
      .push  (stk_push),
      .pop   (stk_pop),
      .din   (pc_q + AW'(1)),
      .dout  (stk_dout),
      .full  (stk_full),
      .empty (stk_empty)
   );

   assign ctl     = decode_op(instr_q[IW-1 -: 4]);
   assign arg     = instr_q[AW-1:0];
   assign consume = instr_vld_q && !stall;

   always_comb begin
      pr_d        = pr_q;
      wr_addr_d   = wr_addr_q;
      fpc_d       = fpc_q;
      pc_d        = pc_q;
      instr_vld_d = instr_vld_q;
      halted_d    = halted_q;
      stk_err_d   = stk_err_q;
      mem_we      = 1'b0;
      rd_en       = 1'b0;
      stk_push    = 1'b0;
      stk_pop     = 1'b0;
      stk_clr     = 1'b0;

      if (en) begin
         pr_d = pr;
         if (pr != pr_q) begin
            instr_vld_d = 1'b0;
            if (pr) begin
               wr_addr_d = '0;
            end else begin
               fpc_d     = '0;
               stk_clr   = 1'b1;
               halted_d  = 1'b0;
               stk_err_d = 1'b0;
            end
         end else if (pr) begin
            if (iin_vld) begin
               mem_we    = 1'b1;
               wr_addr_d = wr_addr_q + AW'(1);
            end
         end else if (!halted_q && !(instr_vld_q && stall)) begin
            if (consume && ctl != CTL_NONE) begin
               // A taken control instruction squashes the fetch in flight.
               instr_vld_d = 1'b0;
               unique case (ctl)
                  CTL_JMP: fpc_d = pc_q + arg;
                  CTL_CALL: begin
                     if (stk_full) begin
                        stk_err_d = 1'b1;
                        halted_d  = 1'b1;
                     end else begin
                        stk_push = 1'b1;
                        fpc_d    = arg;
                     end
                  end
                  CTL_RET: begin
                     if (stk_empty) begin
                        stk_err_d = 1'b1;
                        halted_d  = 1'b1;
                     end else begin
                        stk_pop = 1'b1;
                        fpc_d   = stk_dout;
                     end
                  end
                  CTL_HALT: halted_d = 1'b1;
                  default: ;
               endcase
            end else begin
               rd_en       = 1'b1;
               pc_d        = fpc_q;
               instr_vld_d = 1'b1;
               fpc_d       = fpc_q + AW'(1);
            end
         end
      end

      instr_d = rd_en ? mem[fpc_q] : instr_q;
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_addr_q] <= iin;
   end

   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         pr_q        <= 1'b0;
         wr_addr_q   <= '0;
         fpc_q       <= '0;
         pc_q        <= '0;
         instr_q     <= '0;
         instr_vld_q <= 1'b0;
         halted_q    <= 1'b0;
         stk_err_q   <= 1'b0;
      end else begin
         pr_q        <= pr_d;
         wr_addr_q   <= wr_addr_d;
         fpc_q       <= fpc_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         instr_vld_q <= instr_vld_d;
         halted_q    <= halted_d;
         stk_err_q   <= stk_err_d;
      end
   end

   assign instr     = instr_q;
   assign instr_vld = instr_vld_q;
   assign pc        = pc_q;
   assign wr_addr   = wr_addr_q;
   assign halted    = halted_q;
   assign stk_err   = stk_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: an ISA-level model with a queue
// return stack is compared every cycle, plus hand-computed literal checks.
module tb_instr_fetch_unit;

   localparam int IW = 16;
   localparam int AW = 8;
   localparam int SD = 4;

   logic          clk = 1'b0;
   logic          rstz = 1'b0;
   logic          en = 1'b1;
   logic          pr = 1'b1;
   logic [IW-1:0] iin = '0;
   logic          iin_vld = 1'b0;
   logic          stall = 1'b0;
   logic [IW-1:0] instr;
   logic          instr_vld;
   logic [AW-1:0] pc;
   logic [AW-1:0] wr_addr;
   logic          halted;
   logic          stk_err;
   wire           dvdd = 1'b1;
   wire           dgnd = 1'b0;

   int            n_chk = 0;
   int            n_pass = 0;
   bit            chk_on = 1'b0;
   logic [IW-1:0] prog_q [$];

   instr_fetch_unit #(.IW(IW), .AW(AW), .STACK_DEPTH(SD)) dut (
      .clk       (clk),
      .rstz      (rstz),
      .en        (en),
      .pr        (pr),
      .iin       (iin),
      .iin_vld   (iin_vld),
      .stall     (stall),
      .instr     (instr),
      .instr_vld (instr_vld),
      .pc        (pc),
      .wr_addr   (wr_addr),
      .halted    (halted),
      .stk_err   (stk_err),
      .dvdd      (dvdd),
      .dgnd      (dgnd)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   logic [IW-1:0] m_mem [2**AW];
   logic          m_pr, m_vld, m_halt, m_err, m_adv;
   logic [AW-1:0] m_wr, m_pc, m_next, m_ret;
   logic [IW-1:0] m_word;
   logic [AW-1:0] m_stk [$];

   always @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         m_pr = 1'b0; m_wr = '0; m_vld = 1'b0; m_pc = '0; m_next = '0;
         m_halt = 1'b0; m_err = 1'b0;
         m_stk.delete();
      end else if (en) begin
         if (pr != m_pr) begin
            m_pr  = pr;
            m_vld = 1'b0;
            if (pr) m_wr = '0;
            else begin
               m_next = '0; m_halt = 1'b0; m_err = 1'b0;
               m_stk.delete();
            end
         end else if (pr) begin
            if (iin_vld) begin
               m_mem[m_wr] = iin;
               m_wr = m_wr + 8'd1;
            end
         end else if (!m_halt && !(m_vld && stall)) begin
            m_adv = 1'b1;
            if (m_vld) begin
               m_word = m_mem[m_pc];
               case (m_word[15:12])
                  4'hF: begin m_next = m_pc + m_word[7:0]; m_vld = 1'b0; m_adv = 1'b0; end
                  4'hE: begin
                     m_vld = 1'b0; m_adv = 1'b0;
                     if (m_stk.size() == SD) begin m_err = 1'b1; m_halt = 1'b1; end
                     else begin
                        m_ret = m_pc + 8'd1;
                        m_stk.push_back(m_ret);
                        m_next = m_word[7:0];
                     end
                  end
                  4'hD: begin
                     m_vld = 1'b0; m_adv = 1'b0;
                     if (m_stk.size() == 0) begin m_err = 1'b1; m_halt = 1'b1; end
                     else m_next = m_stk.pop_back();
                  end
                  4'hC: begin m_halt = 1'b1; m_vld = 1'b0; m_adv = 1'b0; end
                  default: ;
               endcase
            end
            if (m_adv) begin
               m_pc   = m_next;
               m_next = m_next + 8'd1;
               m_vld  = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("model instr_vld", 32'(instr_vld), 32'(m_vld));
         if (m_vld) begin
            check("model pc", 32'(pc), 32'(m_pc));
            check("model instr", 32'(instr), 32'(m_mem[m_pc]));
         end
         check("model halted", 32'(halted), 32'(m_halt));
         check("model stk_err", 32'(stk_err), 32'(m_err));
         check("model wr_addr", 32'(wr_addr), 32'(m_wr));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load_prog();
      pr = 1'b1; iin_vld = 1'b0;
      tick();
      foreach (prog_q[i]) begin
         iin = prog_q[i]; iin_vld = 1'b1;
         tick();
      end
      iin_vld = 1'b0;
   endtask

   task automatic run_start();
      pr = 1'b0;
      tick();
      tick();
   endtask

   task automatic expect_out(input string nm, input logic v, input logic [AW-1:0] p, input logic [IW-1:0] w);
      check({nm, " vld"}, 32'(instr_vld), 32'(v));
      if (v) begin
         check({nm, " pc"}, 32'(pc), 32'(p));
         check({nm, " instr"}, 32'(instr), 32'(w));
      end
   endtask

   task automatic wait_pc(input logic [AW-1:0] p);
      int n = 0;
      while (!(instr_vld && pc == p) && n < 400) begin
         tick();
         n++;
      end
      check("reach pc", 32'(instr_vld && pc == p), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tick(); tick();
      check("rst instr", 32'(instr), 32'h0);
      check("rst instr_vld", 32'(instr_vld), 32'h0);
      check("rst pc", 32'(pc), 32'h0);
      check("rst wr_addr", 32'(wr_addr), 32'h0);
      check("rst halted", 32'(halted), 32'h0);
      check("rst stk_err", 32'(stk_err), 32'h0);
      rstz = 1'b1;
      chk_on = 1'b1;

      // basic run and halt
      prog_q = '{16'h1111, 16'h2222, 16'h3333, 16'hC000};
      load_prog();
      check("load wr_addr", 32'(wr_addr), 32'd4);
      run_start();
      expect_out("run0", 1'b1, 8'h00, 16'h1111); tick();
      expect_out("run1", 1'b1, 8'h01, 16'h2222); tick();
      expect_out("run2", 1'b1, 8'h02, 16'h3333); tick();
      expect_out("run3", 1'b1, 8'h03, 16'hC000); tick();
      check("halt vld", 32'(instr_vld), 32'd0);
      check("halt flag", 32'(halted), 32'd1);
      tick();
      check("halt vld hold", 32'(instr_vld), 32'd0);

      // backward jump with stall on the JMP
      prog_q = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hF0FE};
      load_prog();
      run_start();
      wait_pc(8'h05);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_out("stall jmp", 1'b1, 8'h05, 16'hF0FE);
      end
      stall = 1'b0;
      tick(); check("jmp bubble", 32'(instr_vld), 32'd0);
      tick(); expect_out("jmp tgt", 1'b1, 8'h03, 16'h0003);
      tick(); expect_out("jmp once a", 1'b1, 8'h04, 16'h0004);
      tick(); expect_out("jmp once b", 1'b1, 8'h05, 16'hF0FE);

      // call and return
      prog_q.delete();
      for (int i = 0; i < 17; i++) prog_q.push_back(16'h0000);
      prog_q[1] = 16'hE010; prog_q[2] = 16'hC000; prog_q[16] = 16'hD000;
      load_prog();
      run_start();
      expect_out("cr pc0", 1'b1, 8'h00, 16'h0000); tick();
      expect_out("cr call", 1'b1, 8'h01, 16'hE010); tick();
      check("cr bubble1", 32'(instr_vld), 32'd0); tick();
      expect_out("cr ret", 1'b1, 8'h10, 16'hD000); tick();
      check("cr bubble2", 32'(instr_vld), 32'd0); tick();
      expect_out("cr back", 1'b1, 8'h02, 16'hC000); tick();
      check("cr halted", 32'(halted), 32'd1);
      check("cr no err", 32'(stk_err), 32'd0);

      // stack overflow on fifth nested CALL
      prog_q = '{16'hE001, 16'hE002, 16'hE003, 16'hE004, 16'hE005, 16'h0000};
      load_prog();
      run_start();
      wait_pc(8'h04);
      check("ovf before", 32'(stk_err), 32'd0);
      tick();
      check("ovf err", 32'(stk_err), 32'd1);
      check("ovf halted", 32'(halted), 32'd1);
      check("ovf vld", 32'(instr_vld), 32'd0);

      // underflow on RET with empty stack
      prog_q = '{16'hD000};
      load_prog();
      pr = 1'b0;
      tick();
      check("entry clears err", 32'(stk_err), 32'd0);
      check("entry clears halt", 32'(halted), 32'd0);
      tick(); expect_out("unf ret", 1'b1, 8'h00, 16'hD000);
      tick();
      check("unf err", 32'(stk_err), 32'd1);
      check("unf halted", 32'(halted), 32'd1);

      // full memory load, enable freeze, wrap-around and mid-run reset
      prog_q.delete();
      for (int i = 0; i < 256; i++) prog_q.push_back(16'h5A00 | 16'(i));
      load_prog();
      check("load wrap wr_addr", 32'(wr_addr), 32'd0);
      run_start();
      expect_out("wr pc0", 1'b1, 8'h00, 16'h5A00); tick();
      expect_out("wr pc1", 1'b1, 8'h01, 16'h5A01);
      en = 1'b0; pr = 1'b1;
      tick(); expect_out("en0 hold a", 1'b1, 8'h01, 16'h5A01);
      tick(); expect_out("en0 hold b", 1'b1, 8'h01, 16'h5A01);
      en = 1'b1;
      tick(); check("late edge vld", 32'(instr_vld), 32'd0);
      run_start();
      expect_out("re pc0", 1'b1, 8'h00, 16'h5A00);
      wait_pc(8'hFF);
      check("pc ff instr", 32'(instr), 32'h5AFF);
      tick(); expect_out("wrap pc0", 1'b1, 8'h00, 16'h5A00);
      tick(); expect_out("wrap pc1", 1'b1, 8'h01, 16'h5A01);
      #2 rstz = 1'b0;
      #1;
      check("arst instr", 32'(instr), 32'h0);
      check("arst vld", 32'(instr_vld), 32'h0);
      check("arst pc", 32'(pc), 32'h0);
      check("arst wr_addr", 32'(wr_addr), 32'h0);
      check("arst halted", 32'(halted), 32'h0);
      check("arst stk_err", 32'(stk_err), 32'h0);
      pr = 1'b1;
      tick();
      rstz = 1'b1;
      tick();
      run_start();
      expect_out("kept mem0", 1'b1, 8'h00, 16'h5A00); tick();
      expect_out("kept mem1", 1'b1, 8'h01, 16'h5A01); tick();

      chk_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
